dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
Sequences data-memory transactions for the load/store instruction in the memory/writeback path of the pipelined RISC-V core. It takes the decoded controls dmem_sel, w_sel and r_sel plus the address and store data, and drives a req/ack word-wide memory port. Misaligned accesses are split into two word transactions. The block stalls the pipeline until the access completes and returns sign- or zero-extended load data.

Parameters:
TIMEOUT, 255, maximum cycles mem_req may wait for mem_ack in one phase before the access aborts; 0 disables the timeout.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  synchronous, active-low reset
start  in  1  new access presented this cycle
dmem_sel  in  1  1 = store, 0 = load
w_sel  in  2  store width: 00 byte, 01 half, 10 word, 11 none
r_sel  in  3  load type: 000 LB, 010 LH, 011 LW, 100 LBU, 101 LHU, 111 none
addr  in  32  byte address
wdata  in  32  store data, right-aligned
stall  out  1  holds the pipeline
done  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse with done when the access timed out
rdata_out  out  32  extended load result; valid with done and held until the next done
mem_req  out  1  memory request
mem_we  out  1  write enable
mem_addr  out  32  word-aligned address; bits [1:0] are always 00
mem_be  out  4  byte-lane enables
mem_wdata  out  32  lane-aligned write data
mem_ack  in  1  memory accepted the request; mem_rdata is valid in the same cycle
mem_rdata  in  32  read word

Behaviour:
- Reset: clk and rst_n are the only clock and reset. When rst_n is low at a rising edge, all outputs and internal registers go to 0 and the state goes to IDLE. This applies mid-transaction: mem_req drops at that edge, no done is issued, and the access is abandoned.
- Valid op:
  - Store: dmem_sel=1 and w_sel!=11.
  - Load: dmem_sel=0 and r_sel is one of 000/010/011/100/101.
  - Any other combination, and any unlisted r_sel code, is a no-op. A no-op start causes no stall, no mem_req and no done.
- Size n: 1 for byte, 2 for half, 4 for word. Offset o = addr[1:0]. The access is split when o+n>4.
- States: IDLE, ACC0, ACC1.
  - IDLE: a start with a valid op latches all inputs and goes to ACC0. mem_req rises at the next edge.
  - ACC0:
    - mem_addr = {addr[31:2],2'b00}.
    - mem_be = lanes o through min(o+n-1, 3).
    - mem_wdata = low 32 bits of ({32'b0,wdata} << 8*o).
    - On mem_ack: if split, go to ACC1, otherwise go to IDLE and pulse done at that edge.
  - ACC1:
    - mem_addr = ACC0 address + 4, wrapping modulo 2^32.
    - mem_be = lanes 0 through o+n-5.
    - mem_wdata = high 32 bits of the shifted value.
    - On mem_ack: go to IDLE and pulse done.
- Handshake:
  - mem_req, mem_we, mem_addr, mem_be and mem_wdata are registered and stay stable while mem_req=1 and mem_ack=0.
  - mem_req stays high between ACC0 and ACC1; the fields change at the ACC0 ack edge.
  - mem_req=0 in IDLE.
  - mem_ack is ignored while mem_req=0.
- Load result:
  - Assemble {word1,word0} >> 8*o, taking only the low n bytes.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes the word through.
  - rdata_out is registered at the done edge. Stores leave rdata_out unchanged.
- Stall: stall = (state!=IDLE) | (start & valid op & state==IDLE). This is combinational from start only in the accept cycle. stall=0 in the cycle done=1, so the pipeline advances and captures rdata_out.
- start while state!=IDLE is ignored.
- Timeout:
  - The counter clears on entry to ACC0 and on entry to ACC1, and increments each cycle mem_req=1 & mem_ack=0.
  - When it reaches TIMEOUT without an ack, mem_req drops, the state goes to IDLE, and done=1 and err=1 pulse together. rdata_out is unchanged.
  - A mem_ack in the same cycle the count reaches TIMEOUT wins: the access completes normally with no err.
- Latency: for an aligned access with start in cycle 0 and ack in cycle k (k≥1), done=1 in cycle k+1. A split access adds one phase.

Test Plan:
1. LW, addr=0x100, mem_rdata=0xDEADBEEF, ack in the first request cycle -> mem_addr=0x100, be=1111, done two cycles after start, rdata_out=0xDEADBEEF, stall high for exactly 2 cycles.
2. LB, addr=0x203, mem_rdata=0x80000000 -> be=1000, rdata_out=0xFFFFFF80; the same access as LBU -> 0x00000080.
3. SW, addr=0x302, wdata=0x11223344 -> phase 0: addr 0x300, be=1100, wdata=0x33440000; phase 1: addr 0x304, be=0011, wdata=0x00001122; done after the second ack.
4. LH, addr=0x0FF (o=3), words 0xAB000000 then 0x000000CD -> two requests, rdata_out=0xFFFFCDAB.
5. TIMEOUT=4 with mem_ack tied low -> mem_req high for 4 cycles, then mem_req=0 with done=err=1 in the same cycle; a following aligned load completes normally.
6. rst_n low while mid-ACC1 -> at that edge mem_req=0, stall=0, no done; a no-op start (dmem_sel=0, r_sel=111) -> no stall, no mem_req.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer for the load/store path.
// Splits misaligned accesses into two word transactions on a req/ack port.
module dmem_access_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        dmem_sel,
  input  logic [1:0]  w_sel,
  input  logic [2:0]  r_sel,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1} state_t;

  state_t state_q, state_d;

  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [31:0]   maddr_q, maddr_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wd_q, wd_d;
  logic [3:0]    be_hi_q, be_hi_d;
  logic [31:0]   wd_hi_q, wd_hi_d;
  logic          split_q, split_d;
  logic [1:0]    off_q, off_d;
  logic [2:0]    rsel_q, rsel_d;
  logic [31:0]   rd0_q, rd0_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        is_store, is_load, valid_op, accept;
  logic [3:0]  base_be;
  logic [7:0]  mask8;
  logic [63:0] wshift;
  logic        ack_fire, tmo;
  logic [63:0] cat;
  logic [31:0] lw;
  logic [31:0] ext;

  // Decode of the incoming op
  always_comb begin
    is_store = dmem_sel && (w_sel != 2'b11);
    is_load  = !dmem_sel && (r_sel inside {3'b000, 3'b010, 3'b011,
                                           3'b100, 3'b101});
    valid_op = is_store || is_load;
    base_be  = 4'b1111;
    if (dmem_sel) begin
      unique case (1'b1)
        w_sel == 2'b00: base_be = 4'b0001;
        w_sel == 2'b01: base_be = 4'b0011;
        default:        base_be = 4'b1111;
      endcase
    end else begin
      unique case (1'b1)
        r_sel[1:0] == 2'b00: base_be = 4'b0001;
        r_sel == 3'b010:     base_be = 4'b0011;
        r_sel == 3'b101:     base_be = 4'b0011;
        default:             base_be = 4'b1111;
      endcase
    end
    mask8  = {4'b0000, base_be} << addr[1:0];
    wshift = {32'b0, wdata} << {addr[1:0], 3'b000};
    accept = start && valid_op && (state_q == IDLE);
  end

  assign ack_fire = req_q && mem_ack;
  assign tmo = (TIMEOUT != 0) && req_q && !mem_ack &&
               (cnt_q == CW'(TIMEOUT - 1));

  // Load assembly: word1 only exists on the second phase
  always_comb begin
    cat = (state_q == ACC1) ? {mem_rdata, rd0_q} : {32'b0, mem_rdata};
    lw  = 32'(cat >> {off_q, 3'b000});
    unique case (1'b1)
      rsel_q == 3'b000: ext = {{24{lw[7]}}, lw[7:0]};
      rsel_q == 3'b010: ext = {{16{lw[15]}}, lw[15:0]};
      rsel_q == 3'b100: ext = {24'b0, lw[7:0]};
      rsel_q == 3'b101: ext = {16'b0, lw[15:0]};
      default:          ext = lw;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = ACC0;
      ACC0: begin
        if (ack_fire)  state_d = split_q ? ACC1 : IDLE;
        else if (tmo)  state_d = IDLE;
      end
      ACC1: if (ack_fire || tmo) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_d   = req_q;
    we_d    = we_q;
    maddr_d = maddr_q;
    be_d    = be_q;
    wd_d    = wd_q;
    be_hi_d = be_hi_q;
    wd_hi_d = wd_hi_q;
    split_d = split_q;
    off_d   = off_q;
    rsel_d  = rsel_q;
    rd0_d   = rd0_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    if (req_q && !mem_ack && TIMEOUT != 0) cnt_d = cnt_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          req_d   = 1'b1;
          we_d    = dmem_sel;
          maddr_d = {addr[31:2], 2'b00};
          be_d    = mask8[3:0];
          wd_d    = wshift[31:0];
          be_hi_d = mask8[7:4];
          wd_hi_d = wshift[63:32];
          split_d = |mask8[7:4];
          off_d   = addr[1:0];
          rsel_d  = r_sel;
          cnt_d   = '0;
        end
      end
      ACC0, ACC1: begin
        if (ack_fire && state_q == ACC0 && split_q) begin
          rd0_d   = mem_rdata;
          maddr_d = maddr_q + 32'd4;
          be_d    = be_hi_q;
          wd_d    = wd_hi_q;
          cnt_d   = '0;
        end else if (ack_fire || tmo) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          maddr_d = '0;
          be_d    = '0;
          wd_d    = '0;
          done_d  = 1'b1;
          err_d   = !ack_fire;
          if (ack_fire && !we_q) rdata_d = ext;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      maddr_q <= '0;
      be_q    <= '0;
      wd_q    <= '0;
      be_hi_q <= '0;
      wd_hi_q <= '0;
      split_q <= 1'b0;
      off_q   <= '0;
      rsel_q  <= '0;
      rd0_q   <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      req_q   <= req_d;
      we_q    <= we_d;
      maddr_q <= maddr_d;
      be_q    <= be_d;
      wd_q    <= wd_d;
      be_hi_q <= be_hi_d;
      wd_hi_q <= wd_hi_d;
      split_q <= split_d;
      off_q   <= off_d;
      rsel_q  <= rsel_d;
      rd0_q   <= rd0_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall     = (state_q != IDLE) || accept;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata_out = rdata_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = maddr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wd_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl.
// Memory side is driven by hand, one cycle at a time.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        dmem_sel;
  logic [1:0]  w_sel;
  logic [2:0]  r_sel;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall, done, err;
  logic [31:0] rdata_out;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int chk = 0;
  int pass = 0;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dmem_sel(dmem_sel),
    .w_sel(w_sel), .r_sel(r_sel), .addr(addr), .wdata(wdata),
    .stall(stall), .done(done), .err(err), .rdata_out(rdata_out),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic st, input logic [1:0] ws,
                    input logic [2:0] rs, input logic [31:0] a,
                    input logic [31:0] wd);
    start = 1'b1; dmem_sel = st; w_sel = ws; r_sel = rs;
    addr = a; wdata = wd;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; dmem_sel = 1'b0; w_sel = 2'b11;
    r_sel = 3'b111; addr = '0; wdata = '0; mem_ack = 1'b0;
    mem_rdata = '0;
    tick(); tick();
    chk++; if ({mem_req, done, err, stall} !== 4'b0000)
      $display("FAIL rst_ctl got %b exp 0000", {mem_req, done, err, stall});
    else pass++;
    chk++; if (rdata_out !== 32'h0)
      $display("FAIL rst_rdata got %h exp 00000000", rdata_out);
    else pass++;
    chk++; if (mem_be !== 4'h0)
      $display("FAIL rst_be got %b exp 0000", mem_be);
    else pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_lw();
    op(1'b0, 2'b11, 3'b011, 32'h100, 32'h0);
    #1;
    chk++; if ({stall, mem_req} !== 2'b10)
      $display("FAIL lw_c0 got %b exp 10", {stall, mem_req});
    else pass++;
    tick();
    start = 1'b0;
    chk++; if ({stall, mem_req, mem_we, done} !== 4'b1100)
      $display("FAIL lw_c1 got %b exp 1100", {stall, mem_req, mem_we, done});
    else pass++;
    chk++; if ({mem_addr, mem_be} !== {32'h100, 4'b1111})
      $display("FAIL lw_addr_be got %h/%b exp 00000100/1111", mem_addr, mem_be);
    else pass++;
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ack = 1'b0;
    chk++; if ({done, err, stall, mem_req} !== 4'b1000)
      $display("FAIL lw_done got %b exp 1000", {done, err, stall, mem_req});
    else pass++;
    chk++; if (rdata_out !== 32'hDEADBEEF)
      $display("FAIL lw_rdata got %h exp deadbeef", rdata_out);
    else pass++;
    tick();
    chk++; if ({done, rdata_out} !== {1'b0, 32'hDEADBEEF})
      $display("FAIL lw_hold got %b/%h exp 0/deadbeef", done, rdata_out);
    else pass++;
  endtask

  task automatic test_back_to_back();
    op(1'b0, 2'b11, 3'b000, 32'h203, 32'h0);
    tick();
    start = 1'b0;
    chk++; if ({mem_addr, mem_be} !== {32'h200, 4'b1000})
      $display("FAIL lb_addr_be got %h/%b exp 00000200/1000", mem_addr, mem_be);
    else pass++;
    mem_ack = 1'b1; mem_rdata = 32'h80000000;
    tick();
    mem_ack = 1'b0;
    chk++; if ({done, rdata_out} !== {1'b1, 32'hFFFFFF80})
      $display("FAIL lb_rdata got %b/%h exp 1/ffffff80", done, rdata_out);
    else pass++;
    op(1'b0, 2'b11, 3'b100, 32'h203, 32'h0);
    #1;
    chk++; if (stall !== 1'b1)
      $display("FAIL lbu_accept_stall got %b exp 1", stall);
    else pass++;
    tick();
    start = 1'b0;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk++; if ({done, rdata_out} !== {1'b1, 32'h00000080})
      $display("FAIL lbu_rdata got %b/%h exp 1/00000080", done, rdata_out);
    else pass++;
  endtask

  task automatic test_split_store();
    op(1'b1, 2'b10, 3'b111, 32'h302, 32'h11223344);
    tick();
    start = 1'b0;
    chk++; if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata} !==
               {2'b11, 32'h300, 4'b1100, 32'h33440000})
      $display("FAIL sw_p0 got %b %h %b %h exp 1 1 300 1100 33440000",
               mem_req, mem_addr, mem_be, mem_wdata);
    else pass++;
    tick();
    chk++; if ({mem_req, mem_addr, mem_be, mem_wdata} !==
               {1'b1, 32'h300, 4'b1100, 32'h33440000})
      $display("FAIL sw_p0_stable got %b %h %b %h", mem_req, mem_addr,
               mem_be, mem_wdata);
    else pass++;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk++; if ({mem_req, done, mem_addr, mem_be, mem_wdata} !==
               {2'b10, 32'h304, 4'b0011, 32'h00001122})
      $display("FAIL sw_p1 got %b %b %h %b %h exp 1 0 304 0011 00001122",
               mem_req, done, mem_addr, mem_be, mem_wdata);
    else pass++;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk++; if ({done, err, mem_req, rdata_out} !== {3'b100, 32'h00000080})
      $display("FAIL sw_done got %b %b %b %h exp 1 0 0 00000080",
               done, err, mem_req, rdata_out);
    else pass++;
  endtask

  task automatic test_wrap_store();
    op(1'b1, 2'b01, 3'b111, 32'hFFFFFFFF, 32'h0000BEEF);
    tick();
    start = 1'b0;
    chk++; if ({mem_addr, mem_be, mem_wdata} !==
               {32'hFFFFFFFC, 4'b1000, 32'hEF000000})
      $display("FAIL sh_wrap_p0 got %h %b %h", mem_addr, mem_be, mem_wdata);
    else pass++;
    mem_ack = 1'b1;
    tick();
    chk++; if ({mem_addr, mem_be, mem_wdata} !==
               {32'h0, 4'b0001, 32'h000000BE})
      $display("FAIL sh_wrap_p1 got %h %b %h", mem_addr, mem_be, mem_wdata);
    else pass++;
    tick();
    mem_ack = 1'b0;
    chk++; if (done !== 1'b1)
      $display("FAIL sh_wrap_done got %b exp 1", done);
    else pass++;
  endtask

  task automatic test_split_load();
    op(1'b0, 2'b11, 3'b010, 32'h0FF, 32'h0);
    tick();
    start = 1'b0;
    chk++; if ({mem_addr, mem_be} !== {32'h0FC, 4'b1000})
      $display("FAIL lh_p0 got %h/%b exp 000000fc/1000", mem_addr, mem_be);
    else pass++;
    mem_ack = 1'b1; mem_rdata = 32'hAB000000;
    tick();
    chk++; if ({mem_req, mem_addr, mem_be} !== {1'b1, 32'h100, 4'b0001})
      $display("FAIL lh_p1 got %b %h %b exp 1 00000100 0001",
               mem_req, mem_addr, mem_be);
    else pass++;
    mem_rdata = 32'h000000CD;
    tick();
    mem_ack = 1'b0;
    chk++; if ({done, rdata_out} !== {1'b1, 32'hFFFFCDAB})
      $display("FAIL lh_rdata got %b/%h exp 1/ffffcdab", done, rdata_out);
    else pass++;
  endtask

  task automatic test_timeout();
    int hi;
    op(1'b0, 2'b11, 3'b011, 32'h40, 32'h0);
    tick();
    start = 1'b0;
    hi = 0;
    for (int i = 0; i < 4; i++) begin
      if (mem_req === 1'b1 && done === 1'b0) hi++;
      tick();
    end
    chk++; if (hi !== 4)
      $display("FAIL tmo_req_cycles got %0d exp 4", hi);
    else pass++;
    chk++; if ({mem_req, done, err, stall} !== 4'b0110)
      $display("FAIL tmo_abort got %b exp 0110", {mem_req, done, err, stall});
    else pass++;
    chk++; if (rdata_out !== 32'hFFFFCDAB)
      $display("FAIL tmo_rdata got %h exp ffffcdab", rdata_out);
    else pass++;
    op(1'b0, 2'b11, 3'b011, 32'h44, 32'h0);
    tick();
    start = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    tick();
    mem_ack = 1'b0;
    chk++; if ({done, err, rdata_out} !== {2'b10, 32'h12345678})
      $display("FAIL tmo_next got %b %b %h exp 1 0 12345678",
               done, err, rdata_out);
    else pass++;
    op(1'b0, 2'b11, 3'b101, 32'h48, 32'h0);
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    mem_ack = 1'b1; mem_rdata = 32'h0000F00D;
    tick();
    mem_ack = 1'b0;
    chk++; if ({done, err, rdata_out} !== {2'b10, 32'h0000F00D})
      $display("FAIL tmo_ack_wins got %b %b %h exp 1 0 0000f00d",
               done, err, rdata_out);
    else pass++;
  endtask

  task automatic test_reset_mid();
    op(1'b0, 2'b11, 3'b010, 32'h0FF, 32'h0);
    tick();
    start = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hAB000000;
    tick();
    mem_ack = 1'b0;
    chk++; if ({mem_req, mem_addr} !== {1'b1, 32'h100})
      $display("FAIL rmid_in_acc1 got %b %h exp 1 00000100", mem_req, mem_addr);
    else pass++;
    rst_n = 1'b0;
    tick();
    chk++; if ({mem_req, stall, done, err} !== 4'b0000)
      $display("FAIL rmid_abort got %b exp 0000", {mem_req, stall, done, err});
    else pass++;
    rst_n = 1'b1;
    tick();
    op(1'b0, 2'b11, 3'b111, 32'h100, 32'h0);
    #1;
    chk++; if (stall !== 1'b0)
      $display("FAIL noop_stall got %b exp 0", stall);
    else pass++;
    tick();
    op(1'b1, 2'b11, 3'b000, 32'h100, 32'h0);
    tick();
    start = 1'b0;
    chk++; if ({mem_req, stall, done} !== 3'b000)
      $display("FAIL noop_req got %b exp 000", {mem_req, stall, done});
    else pass++;
    tick();
    chk++; if ({mem_req, done} !== 2'b00)
      $display("FAIL noop_done got %b exp 00", {mem_req, done});
    else pass++;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_back_to_back();
    test_split_store();
    test_wrap_store();
    test_split_load();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
